// File: rtl/matmul_tile_sequencer.sv
// Tile sequencer for a MAT_DIM x MAT_DIM matmul on a CORE_DIM x CORE_DIM systolic core.
// Walks tiles in (m, n, k) order, launching one core step per tile and flagging finished C tiles.
module matmul_tile_sequencer #(
  parameter  int MAT_DIM  = 8,
  parameter  int CORE_DIM = 4,
  parameter  int AW       = 7,
  localparam int T        = MAT_DIM / CORE_DIM,
  localparam int TW       = (T > 1) ? $clog2(T) : 1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  input  logic          clear_done,
  input  logic          core_done,
  output logic          core_start,
  output logic          accumulate,
  output logic [AW-1:0] a_addr,
  output logic [AW-1:0] b_addr,
  output logic [AW-1:0] c_addr,
  output logic          c_write,
  output logic [TW-1:0] tile_m,
  output logic [TW-1:0] tile_n,
  output logic [TW-1:0] tile_k,
  output logic          busy,
  output logic          done
);

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_LAUNCH  = 3'd1,
    ST_WAIT    = 3'd2,
    ST_ADVANCE = 3'd3,
    ST_DONE    = 3'd4
  } state_t;

  localparam logic [TW-1:0] LAST = TW'(T - 1);

  state_t        state_q, state_d;
  logic [TW-1:0] m_q, m_d;
  logic [TW-1:0] n_q, n_d;
  logic [TW-1:0] k_q, k_d;
  logic          last_tile_s;

  assign last_tile_s = (m_q == LAST) && (n_q == LAST) && (k_q == LAST);

  // State and tile counter registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      m_q     <= '0;
      n_q     <= '0;
      k_q     <= '0;
    end else begin
      state_q <= state_d;
      m_q     <= m_d;
      n_q     <= n_d;
      k_q     <= k_d;
    end
  end

  // Next-state and counter stepping (k innermost, m outermost)
  always_comb begin
    state_d = state_q;
    m_d     = m_q;
    n_d     = n_q;
    k_d     = k_q;
    case (state_q)
      ST_IDLE: begin
        if (start) state_d = ST_LAUNCH;
        else       state_d = ST_IDLE;
      end
      ST_LAUNCH: begin
        state_d = ST_WAIT;
      end
      ST_WAIT: begin
        if (core_done) state_d = ST_ADVANCE;
        else           state_d = ST_WAIT;
      end
      ST_ADVANCE: begin
        if (k_q == LAST) begin
          k_d = '0;
          if (n_q == LAST) begin
            n_d = '0;
            if (m_q == LAST) m_d = '0;
            else             m_d = m_q + TW'(1);
          end else begin
            n_d = n_q + TW'(1);
          end
        end else begin
          k_d = k_q + TW'(1);
        end
        // Counters wrap to zero on the final tile, so the next run starts at (0,0,0)
        if (last_tile_s) state_d = ST_DONE;
        else             state_d = ST_LAUNCH;
      end
      ST_DONE: begin
        if (clear_done) state_d = ST_IDLE;
        else            state_d = ST_DONE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  assign core_start = (state_q == ST_LAUNCH);
  assign c_write    = (state_q == ST_ADVANCE) && (k_q == LAST);
  assign busy       = (state_q == ST_LAUNCH) || (state_q == ST_WAIT) || (state_q == ST_ADVANCE);
  assign done       = (state_q == ST_DONE);
  assign accumulate = (k_q != '0);

  assign tile_m = m_q;
  assign tile_n = n_q;
  assign tile_k = k_q;

  // Arithmetic done in AW bits gives the required truncation for free
  assign a_addr = (AW'(m_q) * AW'(T) + AW'(k_q)) * AW'(CORE_DIM);
  assign b_addr = (AW'(k_q) * AW'(T) + AW'(n_q)) * AW'(CORE_DIM);
  assign c_addr = (AW'(m_q) * AW'(T) + AW'(n_q)) * AW'(CORE_DIM);

endmodule

// File: tb/tb_matmul_tile_sequencer.sv
// Directed, table-driven bench for matmul_tile_sequencer: default T=2 instance plus a T=1 instance.
module tb_matmul_tile_sequencer;

  logic       clk = 1'b0;
  logic       reset, start, clear_done, core_done;
  logic       core_start, accumulate, c_write, busy, done;
  logic [6:0] a_addr, b_addr, c_addr;
  logic       tile_m, tile_n, tile_k;

  logic       start1, clear1, cdone1;
  logic       core_start1, accumulate1, c_write1, busy1, done1;
  logic [6:0] a_addr1, b_addr1, c_addr1;
  logic       tile_m1, tile_n1, tile_k1;

  always #5 clk = ~clk;

  matmul_tile_sequencer dut (
    .clk(clk), .reset(reset), .start(start), .clear_done(clear_done), .core_done(core_done),
    .core_start(core_start), .accumulate(accumulate), .a_addr(a_addr), .b_addr(b_addr),
    .c_addr(c_addr), .c_write(c_write), .tile_m(tile_m), .tile_n(tile_n), .tile_k(tile_k),
    .busy(busy), .done(done)
  );

  matmul_tile_sequencer #(.MAT_DIM(4), .CORE_DIM(4), .AW(7)) dut1 (
    .clk(clk), .reset(reset), .start(start1), .clear_done(clear1), .core_done(cdone1),
    .core_start(core_start1), .accumulate(accumulate1), .a_addr(a_addr1), .b_addr(b_addr1),
    .c_addr(c_addr1), .c_write(c_write1), .tile_m(tile_m1), .tile_n(tile_n1), .tile_k(tile_k1),
    .busy(busy1), .done(done1)
  );

  typedef struct {
    int         launch;
    logic [6:0] a;
    logic [6:0] b;
    logic       acc;
    logic [2:0] tile;
  } vec_t;

  vec_t       tbl[8];
  logic [6:0] cw_exp[4];

  int         nchk = 0;
  int         nerr = 0;
  int         cyc  = 0;
  int         nl   = 0;
  int         nc   = 0;
  logic [2:0] hist = 3'b000;
  bit         spur_launch = 1'b0;
  logic [6:0] la[16], lb[16], lc[16];
  logic       lacc[16];
  logic [2:0] lt[16];
  int         lcyc[16];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    nchk++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  // One clock: log outputs at the negedge, then model the core replying 3 cycles after launch.
  task automatic step();
    @(negedge clk);
    cyc++;
    if (core_start) begin
      if (nl < 16) begin
        la[nl]   = a_addr;
        lb[nl]   = b_addr;
        lacc[nl] = accumulate;
        lt[nl]   = {tile_m, tile_n, tile_k};
        lcyc[nl] = cyc;
      end
      nl++;
    end
    if (c_write) begin
      if (nc < 16) lc[nc] = c_addr;
      nc++;
    end
    hist      = {hist[1:0], core_start};
    core_done = hist[2] | (spur_launch & core_start);
  endtask

  task automatic clear_log();
    nl   = 0;
    nc   = 0;
    hist = 3'b000;
  endtask

  task automatic run_to_done(input string tg, input int budget);
    for (int i = 0; i < budget && !done; i++) step();
    chk($sformatf("%s_done", tg), done, 1);
    chk($sformatf("%s_length", tg), cyc - lcyc[0], 32);
  endtask

  task automatic check_run(input string tg);
    chk($sformatf("%s_launch_count", tg), nl, 8);
    for (int i = 0; i < 8; i++) begin
      chk($sformatf("%s_a_addr_L%0d", tg, tbl[i].launch), la[i], tbl[i].a);
      chk($sformatf("%s_b_addr_L%0d", tg, tbl[i].launch), lb[i], tbl[i].b);
      chk($sformatf("%s_accum_L%0d", tg, tbl[i].launch), lacc[i], tbl[i].acc);
      chk($sformatf("%s_tile_L%0d", tg, tbl[i].launch), lt[i], tbl[i].tile);
    end
    chk($sformatf("%s_cwrite_count", tg), nc, 4);
    for (int i = 0; i < 4; i++)
      chk($sformatf("%s_c_addr_W%0d", tg, i), lc[i], cw_exp[i]);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // Launch order (m,n,k): 000,001,010,011,100,101,110,111
    tbl[0] = '{1, 7'd0,  7'd0,  1'b0, 3'b000};
    tbl[1] = '{2, 7'd4,  7'd8,  1'b1, 3'b001};
    tbl[2] = '{3, 7'd0,  7'd4,  1'b0, 3'b010};
    tbl[3] = '{4, 7'd4,  7'd12, 1'b1, 3'b011};
    tbl[4] = '{5, 7'd8,  7'd0,  1'b0, 3'b100};
    tbl[5] = '{6, 7'd12, 7'd8,  1'b1, 3'b101};
    tbl[6] = '{7, 7'd8,  7'd4,  1'b0, 3'b110};
    tbl[7] = '{8, 7'd12, 7'd12, 1'b1, 3'b111};
    cw_exp[0] = 7'd0;
    cw_exp[1] = 7'd4;
    cw_exp[2] = 7'd8;
    cw_exp[3] = 7'd12;

    reset = 1'b1; start = 1'b0; clear_done = 1'b0; core_done = 1'b0;
    start1 = 1'b0; clear1 = 1'b0; cdone1 = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_core_start", core_start, 0);
    chk("rst_c_write", c_write, 0);
    chk("rst_addrs", {a_addr, b_addr, c_addr}, 0);
    chk("rst_accumulate", accumulate, 0);
    reset = 1'b0;

    // Spurious core_done while idle
    core_done = 1'b1;
    repeat (3) @(negedge clk);
    core_done = 1'b0;
    chk("idle_spur_busy", busy, 0);
    chk("idle_spur_core_start", core_start, 0);

    // Run 1: start held high for the whole run
    clear_log();
    start = 1'b1;
    run_to_done("run1", 200);
    check_run("run1");
    repeat (5) step();
    chk("run1_done_held", done, 1);
    chk("run1_no_extra_launch", nl, 8);

    // Spurious core_done in DONE
    core_done = 1'b1;
    @(negedge clk);
    core_done = 1'b0;
    @(negedge clk);
    chk("done_spur_done", done, 1);
    chk("done_spur_busy", busy, 0);

    // Clear and start together: clear wins, launch two cycles after clear
    clear_log();
    spur_launch = 1'b1;
    clear_done  = 1'b1;
    step();
    clear_done = 1'b0;
    chk("clear_to_idle_done", done, 0);
    chk("clear_to_idle_busy", busy, 0);
    chk("clear_to_idle_core_start", core_start, 0);
    step();
    chk("launch_2_after_clear", core_start, 1);
    run_to_done("run2", 200);
    check_run("run2");
    spur_launch = 1'b0;

    // Run 3: reset during WAIT of launch 5
    clear_log();
    clear_done = 1'b1;
    step();
    clear_done = 1'b0;
    for (int i = 0; i < 100 && nl < 5; i++) step();
    chk("run3_reach_launch5", nl, 5);
    step();
    chk("run3_wait_busy", busy, 1);
    chk("run3_wait_a_addr", a_addr, 8);
    #2 reset = 1'b1;
    #1;
    chk("midrst_busy", busy, 0);
    chk("midrst_done", done, 0);
    chk("midrst_core_start", core_start, 0);
    chk("midrst_c_write", c_write, 0);
    chk("midrst_addrs", {a_addr, b_addr, c_addr}, 0);
    chk("midrst_accumulate", accumulate, 0);
    chk("midrst_tiles", {tile_m, tile_n, tile_k}, 0);
    start = 1'b0;
    core_done = 1'b0;
    hist = 3'b000;
    @(negedge clk);
    reset = 1'b0;
    step();
    step();
    chk("postrst_idle_busy", busy, 0);
    clear_log();
    start = 1'b1;
    step();
    start = 1'b0;
    chk("restart_launch", nl, 1);
    chk("restart_tile", lt[0], 3'b000);
    chk("restart_addrs", {la[0], lb[0]}, 0);
    chk("restart_accumulate", lacc[0], 0);
    run_to_done("run4", 200);

    // T=1 instance: single launch and single C write
    start1 = 1'b1;
    @(negedge clk);
    start1 = 1'b0;
    chk("t1_core_start", core_start1, 1);
    chk("t1_accumulate", accumulate1, 0);
    chk("t1_busy", busy1, 1);
    @(negedge clk);
    chk("t1_wait_core_start", core_start1, 0);
    chk("t1_wait_c_write", c_write1, 0);
    cdone1 = 1'b1;
    @(negedge clk);
    cdone1 = 1'b0;
    chk("t1_c_write", c_write1, 1);
    chk("t1_c_addr", c_addr1, 0);
    @(negedge clk);
    chk("t1_done", done1, 1);
    chk("t1_done_busy", busy1, 0);
    chk("t1_no_extra_launch", core_start1, 0);

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule

// File: doc/matmul_tile_sequencer.md
MATMUL_TILE_SEQUENCER -- requirements
Module: matmul_tile_sequencer

Interface
REQ-001 SHALL have parameter MAT_DIM, default 8, meaning the full square matrix dimension.
REQ-002 SHALL have parameter CORE_DIM, default 4, meaning the square systolic core dimension.
REQ-003 SHALL have parameter AW, default 7, meaning the RAM address width.
REQ-004 SHALL have port clk, input, 1, single clock; all state updates on rising edge.
REQ-005 SHALL have port reset, input, 1, asynchronous active-high reset.
REQ-006 SHALL have port start, input, 1, level request to run one full MAT_DIM matmul.
REQ-007 SHALL have port clear_done, input, 1, acknowledges done.
REQ-008 SHALL have port core_done, input, 1, one-cycle pulse from core: current tile step finished.
REQ-009 SHALL have port core_start, output, 1, one-cycle pulse launching one core tile step.
REQ-010 SHALL have port accumulate, output, 1, core adds into previous partial sum (tile_k != 0).
REQ-011 SHALL have ports a_addr, b_addr and c_addr, output, AW each, tile base addresses.
REQ-012 SHALL have port c_write, output, 1, one-cycle pulse: finished C tile is valid at c_addr.
REQ-013 SHALL have ports tile_m, tile_n and tile_k, output, $clog2(T) each (min 1), current tile indices, with T = MAT_DIM/CORE_DIM.
REQ-014 SHALL have ports busy and done, output, 1 each, run in progress / run complete (sticky).

Function
REQ-015 SHALL require MAT_DIM to be an integer multiple of CORE_DIM (T >= 1), with T*T*CORE_DIM <= 2^AW; other configurations are unsupported.
REQ-016 SHALL implement FSM states IDLE, LAUNCH, WAIT, ADVANCE, DONE.
REQ-017 SHALL take the transition IDLE -> LAUNCH when start=1 is sampled; otherwise it stays in IDLE.
REQ-018 SHALL assert core_start for exactly the LAUNCH cycle, then go LAUNCH -> WAIT unconditionally.
REQ-019 SHALL take the transition WAIT -> ADVANCE on core_done=1; core_done in any other state is ignored.
REQ-020 SHALL step the counters in ADVANCE in loop order m outer, n middle, k inner: k increments; at k=T-1, k wraps to 0 and n increments; at n=T-1, n wraps and m increments.
REQ-021 SHALL take the transition ADVANCE -> DONE when m=n=k=T-1, else ADVANCE -> LAUNCH.
REQ-022 SHALL pulse c_write in the ADVANCE cycle iff tile_k=T-1, with c_addr still showing the pre-increment tile.
REQ-023 SHALL compute a_addr = (tile_m*T + tile_k)*CORE_DIM, b_addr = (tile_k*T + tile_n)*CORE_DIM and c_addr = (tile_m*T + tile_n)*CORE_DIM, truncated to AW bits.
REQ-024 SHALL make the address outputs combinational from the tile counters, stable from LAUNCH through ADVANCE.
REQ-025 SHALL drive accumulate = (tile_k != 0) and hold it stable while core_start is pulsed.
REQ-026 SHALL assert busy in LAUNCH, WAIT and ADVANCE only.
REQ-027 SHALL assert done in DONE only; DONE holds until clear_done=1, then DONE -> IDLE.
REQ-028 SHALL, on clear_done=1 coinciding with start=1 in DONE, let clear win: go to IDLE and sample start on the next cycle.
REQ-029 SHALL ignore clear_done outside DONE, and ignore start outside IDLE.
REQ-030 SHALL issue exactly T^3 core_start pulses and T^2 c_write pulses per run.
REQ-031 SHALL support T=1 (MAT_DIM=CORE_DIM): one launch, accumulate=0, c_write on the first ADVANCE, then DONE.
REQ-032 SHALL have a minimum latency of 1 cycle from start sampled to core_start.

Reset
REQ-033 SHALL, on reset=1 (asynchronous, at any time including mid-run), immediately force state IDLE, tile counters 0, and core_start, c_write, busy and done to 0.
REQ-034 SHALL show a_addr=b_addr=c_addr=0 and accumulate=0 during reset.
REQ-035 SHALL, after reset deasserts, idle until start=1; no partial run resumes.

Verification
REQ-036 SHALL cover: defaults (T=2), start held high, core_done returned 3 cycles after each core_start -> 8 core_start pulses, a_addr sequence 0,4,0,4,8,12,8,12, b_addr 0,8,4,12,0,8,4,12, 4 c_write pulses at c_addr 0,4,8,12, then done=1 held.
REQ-037 SHALL cover: accumulate check -> accumulate=0 on launches 1,3,5,7 and accumulate=1 on launches 2,4,6,8.
REQ-038 SHALL cover: done=1, then clear_done=1 with start=1 in the same cycle -> IDLE first, second run's core_start 2 cycles after clear; second run is identical to the first.
REQ-039 SHALL cover: reset pulsed during WAIT of launch 5 -> all outputs 0 asynchronously; a later start restarts at tile (0,0,0).
REQ-040 SHALL cover: spurious core_done in IDLE and DONE, and during the LAUNCH cycle -> no state change, no extra pulses.
REQ-041 SHALL cover: MAT_DIM=4, CORE_DIM=4 -> one core_start, one c_write at c_addr 0, done asserted.
